// File: rtl/spram_bist_if.sv
// SRAM port between the BIST initiator (master) and the single-port
// byte-enable SRAM (slave).
interface spram_bist_if #(
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 32
);
    logic [ADDR_BITS-1:0]   m_adr;
    logic [DATA_BITS-1:0]   m_dat_o;
    logic [DATA_BITS-1:0]   m_dat_i;
    logic                   m_we;
    logic [DATA_BITS/8-1:0] m_sel;

    modport master (output m_adr, output m_dat_o, output m_we, output m_sel, input m_dat_i);
    modport slave  (input m_adr, input m_dat_o, input m_we, input m_sel, output m_dat_i);
endinterface

// File: rtl/spram_bist.sv
// March C- built-in self-test for the payload single-port SRAM: W0 up,
// RW1 up, RW0 down, R0 down; captures the first mismatch and reports pass/fail.
module spram_bist #(
    parameter int                   ADDR_BITS = 9,
    parameter int                   DATA_BITS = 32,
    parameter logic [DATA_BITS-1:0] PATTERN   = 32'h5555_AAAA
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [ADDR_BITS-1:0] fail_adr,
    output logic [DATA_BITS-1:0] fail_exp,
    output logic [DATA_BITS-1:0] fail_got,
    spram_bist_if.master         mem
);
    localparam int WORD_BITS = ADDR_BITS - 2;
    localparam int LANES     = DATA_BITS / 8;
    localparam logic [WORD_BITS-1:0] W_LAST = '1;

    typedef enum logic [3:0] {
        IDLE, W0, RW1_RD, RW1_WR, RW0_RD, RW0_WR, R0_RD, R0_CMP, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_BITS-1:0]   w_q, w_d;
    logic                   busy_q, busy_d;
    logic                   done_q;
    logic                   we_q, we_d;
    logic [ADDR_BITS-1:0]   adr_q, adr_d;
    logic [DATA_BITS-1:0]   dat_q, dat_d;
    logic                   pass_q, fail_q;
    logic [ADDR_BITS-1:0]   fail_adr_q;
    logic [DATA_BITS-1:0]   fail_exp_q, fail_got_q;
    logic                   cmp_en;
    logic [DATA_BITS-1:0]   exp_word;
    logic                   mismatch;

    always_comb begin
        cmp_en   = 1'b0;
        exp_word = PATTERN;
        case (state_q)
            RW1_WR: cmp_en = 1'b1;
            RW0_WR: begin
                cmp_en   = 1'b1;
                exp_word = ~PATTERN;
            end
            R0_CMP: cmp_en = 1'b1;
            default: ;
        endcase
    end

    assign mismatch = cmp_en && (mem.m_dat_i != exp_word);

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = W0;
                w_d     = '0;
            end
            W0: if (w_q == W_LAST) begin
                state_d = RW1_RD;
                w_d     = '0;
            end else begin
                w_d = w_q + 1'b1;
            end
            RW1_RD: state_d = RW1_WR;
            RW1_WR: if (mismatch) begin
                state_d = DONE;
            end else if (w_q == W_LAST) begin
                state_d = RW0_RD;
                w_d     = W_LAST;
            end else begin
                state_d = RW1_RD;
                w_d     = w_q + 1'b1;
            end
            RW0_RD: state_d = RW0_WR;
            RW0_WR: if (mismatch) begin
                state_d = DONE;
            end else if (w_q == '0) begin
                state_d = R0_RD;
                w_d     = W_LAST;
            end else begin
                state_d = RW0_RD;
                w_d     = w_q - 1'b1;
            end
            R0_RD:  state_d = R0_CMP;
            R0_CMP: if (mismatch || w_q == '0) begin
                state_d = DONE;
            end else begin
                state_d = R0_RD;
                w_d     = w_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Port values are decoded from the next state so they are registered
        // and line up with the state they belong to.
        busy_d = !(state_d inside {IDLE, DONE});
        we_d   = state_d inside {W0, RW1_WR, RW0_WR};
        adr_d  = busy_d ? {w_d, 2'b00} : '0;
        dat_d  = '0;
        if (state_d == W0 || state_d == RW0_WR)
            dat_d = PATTERN;
        else if (state_d == RW1_WR)
            dat_d = ~PATTERN;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            w_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            fail_adr_q <= '0;
            fail_exp_q <= '0;
            fail_got_q <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            busy_q  <= busy_d;
            done_q  <= (state_d == DONE);
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            if (state_q == IDLE && start) begin
                pass_q     <= 1'b0;
                fail_q     <= 1'b0;
                fail_adr_q <= '0;
                fail_exp_q <= '0;
                fail_got_q <= '0;
            end
            if (mismatch) begin
                fail_q     <= 1'b1;
                fail_adr_q <= adr_q;
                fail_exp_q <= exp_word;
                fail_got_q <= mem.m_dat_i;
            end
            if (state_q == R0_CMP && !mismatch && w_q == '0)
                pass_q <= 1'b1;
        end
    end

    // Read data only arrives in the compare cycle, so the write strobe of a
    // read-modify-write is gated by that cycle's compare result.
    assign mem.m_we    = we_q & ~mismatch;
    assign mem.m_sel   = {LANES{mem.m_we}};
    assign mem.m_adr   = adr_q;
    assign mem.m_dat_o = dat_q;

    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail     = fail_q;
    assign fail_adr = fail_adr_q;
    assign fail_exp = fail_exp_q;
    assign fail_got = fail_got_q;
endmodule

// File: tb/tb_spram_bist.sv
// Bench for spram_bist: faulty-SRAM model, March C- reference model and a
// scoreboard checked by a monitor on every done pulse.
module tb_spram_bist;
    localparam int AB = 4;
    localparam int N  = 1 << (AB - 2);
    localparam logic [31:0] P = 32'h5555_AAAA;

    typedef struct packed {
        logic          pass;
        logic          fail;
        logic [AB-1:0] adr;
        logic [31:0]   exp;
        logic [31:0]   got;
        logic [15:0]   busy;
        logic [15:0]   writes;
        logic [N*32-1:0] mem;
    } exp_t;

    logic clock, reset_n, start;
    logic busy, done, pass, fail;
    logic [AB-1:0] fail_adr;
    logic [31:0] fail_exp, fail_got;

    spram_bist_if #(.ADDR_BITS(AB), .DATA_BITS(32)) bus ();

    spram_bist #(.ADDR_BITS(AB), .DATA_BITS(32), .PATTERN(P)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .fail_adr(fail_adr), .fail_exp(fail_exp), .fail_got(fail_got),
        .mem(bus)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int runs = 0;
    int tot_wr = 0;
    exp_t sb[$];

    // memory fault configuration: 0 good, 1 stuck bit, 2 address alias
    int unsigned fmode = 0;
    int unsigned stuck_word = 0, stuck_bit = 0, alias_src = 0, alias_dst = 0;
    logic stuck_val = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    function automatic int unsigned phys(int unsigned w);
        return (fmode == 2 && w == alias_src) ? alias_dst : w;
    endfunction

    function automatic logic [31:0] fault_val(int unsigned p, logic [31:0] v);
        logic [31:0] r = v;
        if (fmode == 1 && p == stuck_word) r[stuck_bit] = stuck_val;
        return r;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] sel);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // SRAM model with registered read data
    logic [31:0] mem [N];
    logic [31:0] rdata;
    int unsigned widx;
    assign widx = 32'(bus.m_adr[AB-1:2]);
    assign bus.m_dat_i = rdata;

    always @(posedge clock) begin
        rdata <= mem[phys(widx)];
        if (bus.m_we)
            mem[phys(widx)] <= fault_val(phys(widx), merge(mem[phys(widx)], bus.m_dat_o, bus.m_sel));
    end

    // Reference: March C- over the faulty memory as plain array operations
    logic [31:0] ref_mem [N];

    function automatic void ref_write(int unsigned w, logic [31:0] d);
        ref_mem[phys(w)] = fault_val(phys(w), d);
    endfunction

    function automatic exp_t ref_run();
        exp_t e;
        int unsigned cmps = 0, writes = 0, w;
        logic [31:0] ex;
        bit stop = 0;
        e = '0;
        for (int i = 0; i < N; i++) ref_mem[i] = mem[i];
        for (int unsigned i = 0; i < N; i++) begin
            ref_write(i, P);
            writes++;
        end
        for (int el = 0; el < 3 && !stop; el++) begin
            ex = (el == 1) ? ~P : P;
            for (int unsigned k = 0; k < N && !stop; k++) begin
                w = (el == 0) ? k : N - 1 - k;
                cmps++;
                if (ref_mem[phys(w)] !== ex) begin
                    stop  = 1;
                    e.fail = 1'b1;
                    e.adr = AB'(w * 4);
                    e.exp = ex;
                    e.got = ref_mem[phys(w)];
                end else if (el != 2) begin
                    ref_write(w, ~ex);
                    writes++;
                end
            end
        end
        e.pass   = !stop;
        e.busy   = 16'(N + 2 * cmps);
        e.writes = 16'(writes);
        for (int i = 0; i < N; i++) e.mem[32*i +: 32] = ref_mem[i];
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse
    initial begin
        int run_busy = 0, run_wr = 0;
        bit sel_bad = 0;
        exp_t e;
        logic [N*32-1:0] act;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                run_busy = 0;
                run_wr   = 0;
                sel_bad  = 0;
            end else begin
                if (busy) run_busy++;
                if (bus.m_we) begin
                    run_wr++;
                    tot_wr++;
                end
                if (bus.m_sel != {4{bus.m_we}} || bus.m_adr[1:0] != 2'b00) sel_bad = 1;
                if (done) begin
                    done_cnt++;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_done: got done pulse, required none (queue empty)");
                    end else begin
                        e = sb.pop_front();
                        for (int i = 0; i < N; i++) act[32*i +: 32] = mem[i];
                        check("pass", pass, e.pass);
                        check("fail", fail, e.fail);
                        check("fail_adr", fail_adr, e.adr);
                        check("fail_exp", fail_exp, e.exp);
                        check("fail_got", fail_got, e.got);
                        check("busy_cycles", run_busy, e.busy);
                        check("write_count", run_wr, e.writes);
                        check("sel_adr_rules", sel_bad, 0);
                        check("memory", act, e.mem);
                    end
                    run_busy = 0;
                    run_wr   = 0;
                    sel_bad  = 0;
                end
            end
        end
    end

    task automatic run_one(input bit stray);
        exp_t e;
        int target, si;
        e = ref_run();
        sb.push_back(e);
        runs++;
        repeat ($urandom_range(1, 4)) @(negedge clock);
        target = done_cnt + 1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_adr", bus.m_adr, 0);
        check("start_we", bus.m_we, 1);
        if (stray) begin
            si = $urandom_range(2, int'(e.busy));
            repeat (si - 1) @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        for (int c = 0; c < 300 && done_cnt < target; c++) @(negedge clock);
        if (done_cnt < target) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done within 300 cycles, required done");
            sb.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_fail_adr", fail_adr, 0);
        check("rst_fail_exp", fail_exp, 0);
        check("rst_fail_got", fail_got, 0);
        check("rst_m_adr", bus.m_adr, 0);
        check("rst_m_dat_o", bus.m_dat_o, 0);
        check("rst_m_we", bus.m_we, 0);
        check("rst_m_sel", bus.m_sel, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("idle_busy", busy, 0);
        check("idle_writes", tot_wr, 0);

        // good memory with an ignored start during the run
        fmode = 0;
        run_one(1'b1);
        check("good_pass", pass, 1);
        check("good_fail", fail, 0);

        // bit 0 of word 8 stuck at 0
        fmode = 1; stuck_word = 2; stuck_bit = 0; stuck_val = 1'b0;
        run_one(1'b0);
        check("stuck_adr", fail_adr, 8);
        check("stuck_exp", fail_exp, 32'hAAAA_5555);
        check("stuck_got", fail_got, 32'hAAAA_5554);
        check("stuck_pass", pass, 0);

        // address 4 aliased onto address 0
        fmode = 2; alias_src = 1; alias_dst = 0;
        run_one(1'b0);
        check("alias_adr", fail_adr, 4);
        check("alias_exp", fail_exp, 32'h5555_AAAA);
        check("alias_got", fail_got, 32'hAAAA_5555);
        check("alias_fail", fail, 1);

        // reset during the first RW0_WR cycle (busy cycle 3N+2)
        fmode = 0;
        repeat (2) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3 * N + 1) @(negedge clock);
        check("rw0_we_before_reset", bus.m_we, 1);
        check("rw0_adr_before_reset", bus.m_adr, (N - 1) * 4);
        #2 reset_n = 1'b0;
        #1;
        check("abort_we", bus.m_we, 0);
        check("abort_sel", bus.m_sel, 0);
        check("abort_busy", busy, 0);
        check("abort_pass", pass, 0);
        check("abort_fail", fail, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_one(1'b0);
        check("after_abort_pass", pass, 1);

        for (int i = 0; i < 14; i++) begin
            fmode      = $urandom_range(0, 2);
            stuck_word = $urandom_range(0, N - 1);
            stuck_bit  = $urandom_range(0, 31);
            stuck_val  = 1'($urandom_range(0, 1));
            alias_src  = $urandom_range(0, N - 1);
            alias_dst  = (alias_src + $urandom_range(1, N - 1)) % N;
            run_one(1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clock);
        check("scoreboard_empty", sb.size(), 0);
        check("done_pulses", done_cnt, runs);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spram_bist.md
# spram_bist

Built-in self-test initiator for the single-port byte-enable SRAM used in the firmware payload. It drives the SRAM's address, write-data, write-enable and byte-select port and checks its registered read data. It runs a March C- style sequence across every 32-bit word and reports pass/fail. On failure it captures the first failing address, the expected data and the data read back. It sits between a control register block, which supplies `start` and reads the status, and the SRAM port, where it is muxed with the normal bus path.

## Interface
- `ADDR_BITS`, default 9: width of the SRAM byte address. Words tested N = 2^(ADDR_BITS-2).
- `DATA_BITS`, default 32: data width. Fixed at 32; byte lanes = 4.
- `PATTERN`, default 32'h5555_AAAA: background pattern P. The complement is ~P.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a run; sampled only in IDLE.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  sticky: last run completed with no mismatch.
- `fail`  out  1  sticky: last run stopped on a mismatch.
- `fail_adr`  out  ADDR_BITS  byte address of the first mismatch.
- `fail_exp`  out  32  expected word at the first mismatch.
- `fail_got`  out  32  word read back at the first mismatch.
- `m_adr`  out  ADDR_BITS  SRAM byte address; bits [1:0] always 0.
- `m_dat_o`  out  32  SRAM write data.
- `m_dat_i`  in  32  SRAM read data; registered, valid 1 cycle after the address.
- `m_we`  out  1  SRAM write enable.
- `m_sel`  out  4  SRAM byte selects; 4'hF whenever `m_we`=1, otherwise 0.

## Operation
- States: IDLE, W0, RW1_RD, RW1_WR, RW0_RD, RW0_WR, R0_RD, R0_CMP, DONE.
- Word index w runs 0..N-1. `m_adr` = w<<2.
  - "Up" phases run w from 0 to N-1.
  - "Down" phases run w from N-1 to 0.
- IDLE: all `m_*` outputs are 0. When `start`=1, clear `pass`, `fail` and the fail_* registers, set w=0, and go to W0.
- W0 (up), 1 cycle per word: `m_we`=1, `m_dat_o`=P. After the last word, set w=0 and go to RW1_RD.
- RW1_RD (up): present the address with `m_we`=0. Next state is RW1_WR.
- RW1_WR: compare `m_dat_i` against P.
  - Match: `m_we`=1, `m_dat_o`=~P, then advance w. After the last word, set w=N-1 and go to RW0_RD.
- RW0_RD / RW0_WR (down): same structure as RW1, but expect ~P and write P. After the last word, set w=N-1 and go to R0_RD.
- R0_RD / R0_CMP (down): read and expect P, with no write. After the last word, go to DONE.
- Mismatch in any compare state:
  - Suppress the write (`m_we`=0 in that cycle).
  - Load `fail_adr`=`m_adr`, `fail_exp`=expected word, `fail_got`=`m_dat_i`.
  - Set `fail`=1 and go to DONE.
- DONE, 1 cycle: `done`=1, `busy`=0, `pass`=!`fail`. Next state is IDLE.
- `start` outside IDLE is ignored. If `start` is still high in IDLE after DONE, a new run begins.
- The address counter never wraps. The end-of-phase test uses w==N-1 (up) or w==0 (down).

## Timing
- Reset (async, immediate): state = IDLE. Every output is 0, including `m_we`, `m_sel`, `pass`, `fail` and all fail_* registers.
- Reset mid-run aborts immediately: `m_we` drops without waiting for a clock edge, and no status is retained.
- `start` is sampled at edge k. At edge k+1 the block is in W0 with `busy`=1, `m_adr`=0 and `m_we`=1.
- Passing run: `busy` is high for exactly 7N cycles (W0: N, each RW phase: 2N, R0: 2N). `done` follows in the next cycle.
- Failing run: `done` is asserted in the cycle after the failing compare.
- All outputs are registered. `m_dat_i` is sampled only in the *_WR and R0_CMP states.

## Test plan
Every scenario uses ADDR_BITS=4 (N=4, addresses 0, 4, 8, 12) and PATTERN=32'h5555_AAAA.
- Reset: hold `reset_n`=0 -> all outputs 0. Release -> `busy`=0, no SRAM writes.
- Good SRAM model, `start` pulsed -> `busy` high for 28 cycles, then `done` pulse.
  - Status: `pass`=1, `fail`=0.
  - Exactly 12 writes, all with `m_sel`=4'hF. Final memory content is 5555_AAAA in every word.
- Model with bit 0 of word 8 stuck at 0 -> fail in phase RW0 (down, after word 12).
  - `fail_adr`=8, `fail_exp`=AAAA_5555, `fail_got`=AAAA_5554, `pass`=0.
  - No write to address 8 in the failing cycle.
- Model aliasing address 4 onto address 0 -> fail in RW1 at word 4.
  - `fail_adr`=4, `fail_exp`=5555_AAAA, `fail_got`=AAAA_5555.
- `start` pulsed during the RW1 phase -> ignored. Run length stays 28 cycles with a single `done` pulse.
- `reset_n` asserted in RW0_WR -> `m_we`=0 at once, `busy`=0, `pass`=`fail`=0.
  - A fresh `start` afterwards completes a normal passing run.
